// File: rtl/aha_sram_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 4K x 64 SRAM wrapper.
// Grants are combinational; read data returns one cycle after the grant.
module aha_sram_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic        LOCK0,
   input  logic        LOCK1,
   input  logic [7:0]  WE0,
   input  logic [7:0]  WE1,
   input  logic [11:0] ADDR0,
   input  logic [11:0] ADDR1,
   input  logic [63:0] WDATA0,
   input  logic [63:0] WDATA1,
   output logic        GNT0,
   output logic        GNT1,
   output logic        RVALID0,
   output logic        RVALID1,
   output logic [63:0] RDATA0,
   output logic [63:0] RDATA1,
   output logic        SRAM_CEn,
   output logic [7:0]  SRAM_WEn,
   output logic [11:0] SRAM_A,
   output logic [63:0] SRAM_D,
   input  logic [63:0] SRAM_Q
);

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   logic        last_reg, last_next;
   logic        last_lock_reg, last_lock_next;
   logic        prev_gnt_reg;
   logic [3:0]  burst_cnt_reg, burst_cnt_next;
   logic        rd_pend_reg, rd_pend_next;
   logic        rd_port_reg;

   logic        gnt_any;
   logic        win;
   logic        sel_lock;
   logic [7:0]  sel_we;
   logic [11:0] sel_addr;
   logic [63:0] sel_wdata;
   logic [1:0]  rvalid;
   logic [63:0] rdata [2];

   // Arbitration: a lone requester always wins; under contention the
   // previous winner keeps the slot only while its locked burst is short.
   always_comb begin
      gnt_any = REQ0 | REQ1;
      win     = REQ1;
      if (REQ0 && REQ1) begin
         if (last_lock_reg && (burst_cnt_reg < BURST_LIMIT))
            win = last_reg;
         else
            win = ~last_reg;
      end
   end

   assign GNT0 = gnt_any & ~win;
   assign GNT1 = gnt_any & win;

   assign sel_lock  = win ? LOCK1  : LOCK0;
   assign sel_we    = win ? WE1    : WE0;
   assign sel_addr  = win ? ADDR1  : ADDR0;
   assign sel_wdata = win ? WDATA1 : WDATA0;

   assign SRAM_CEn = ~gnt_any;
   assign SRAM_WEn = gnt_any ? ~sel_we   : 8'hFF;
   assign SRAM_A   = gnt_any ? sel_addr  : 12'h000;
   assign SRAM_D   = gnt_any ? sel_wdata : 64'h0;

   always_comb begin
      last_next      = last_reg;
      last_lock_next = last_lock_reg;
      burst_cnt_next = 4'd0;
      rd_pend_next   = 1'b0;
      if (gnt_any) begin
         last_next      = win;
         last_lock_next = sel_lock;
         rd_pend_next   = (sel_we == 8'h00);
         // Count only an unbroken, locked run by the same port.
         if (prev_gnt_reg && (win == last_reg) && last_lock_reg)
            burst_cnt_next = (burst_cnt_reg == 4'hF) ? 4'hF : burst_cnt_reg + 4'd1;
         else
            burst_cnt_next = 4'd1;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         last_reg      <= 1'b1;
         last_lock_reg <= 1'b0;
         prev_gnt_reg  <= 1'b0;
         burst_cnt_reg <= 4'd0;
         rd_pend_reg   <= 1'b0;
         rd_port_reg   <= 1'b0;
      end else begin
         last_reg      <= last_next;
         last_lock_reg <= last_lock_next;
         prev_gnt_reg  <= gnt_any;
         burst_cnt_reg <= burst_cnt_next;
         rd_pend_reg   <= rd_pend_next;
         rd_port_reg   <= win;
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_resp
         assign rvalid[gi] = rd_pend_reg && (rd_port_reg == 1'(gi));
         assign rdata[gi]  = rvalid[gi] ? SRAM_Q : 64'h0;
      end
   endgenerate

   assign RVALID0 = rvalid[0];
   assign RVALID1 = rvalid[1];
   assign RDATA0  = rdata[0];
   assign RDATA1  = rdata[1];

endmodule

// File: tb/tb_aha_sram_arbiter.sv
// Scoreboard bench for aha_sram_arbiter with a behavioural SRAM wrapper model.
module tb_aha_sram_arbiter;

   logic        CLK, RESET;
   logic        REQ0, REQ1, LOCK0, LOCK1;
   logic [7:0]  WE0, WE1;
   logic [11:0] ADDR0, ADDR1;
   logic [63:0] WDATA0, WDATA1;
   logic        GNT0, GNT1, RVALID0, RVALID1;
   logic [63:0] RDATA0, RDATA1;
   logic        SRAM_CEn;
   logic [7:0]  SRAM_WEn;
   logic [11:0] SRAM_A;
   logic [63:0] SRAM_D, SRAM_Q;

   aha_sram_arbiter #(.MAX_BURST(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ0(REQ0), .REQ1(REQ1), .LOCK0(LOCK0), .LOCK1(LOCK1),
      .WE0(WE0), .WE1(WE1), .ADDR0(ADDR0), .ADDR1(ADDR1),
      .WDATA0(WDATA0), .WDATA1(WDATA1),
      .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
      .RDATA0(RDATA0), .RDATA1(RDATA1),
      .SRAM_CEn(SRAM_CEn), .SRAM_WEn(SRAM_WEn), .SRAM_A(SRAM_A),
      .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // SRAM wrapper model: synchronous, active-low enables, registered Q on reads.
   logic [63:0] mem [4096];
   always @(posedge CLK) begin
      if (!SRAM_CEn) begin
         if (SRAM_WEn == 8'hFF)
            SRAM_Q <= mem[SRAM_A];
         else
            for (int b = 0; b < 8; b++)
               if (!SRAM_WEn[b]) mem[SRAM_A][8*b +: 8] <= SRAM_D[8*b +: 8];
      end
   end

   typedef struct packed {
      logic        port;
      logic [7:0]  wen;
      logic [11:0] a;
      logic [63:0] d;
   } gnt_t;

   gnt_t        exp_gnt [$];
   logic [63:0] exp_rd0 [$];
   logic [63:0] exp_rd1 [$];
   int          checks = 0;
   int          errors = 0;
   bit          run = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic l0, input logic [7:0] w0,
                        input logic [11:0] a0, input logic [63:0] d0,
                        input logic r1, input logic l1, input logic [7:0] w1,
                        input logic [11:0] a1, input logic [63:0] d1);
      REQ0 = r0; LOCK0 = l0; WE0 = w0; ADDR0 = a0; WDATA0 = d0;
      REQ1 = r1; LOCK1 = l1; WE1 = w1; ADDR1 = a1; WDATA1 = d1;
   endtask

   task automatic idle();
      drive(0, 0, 8'h00, 12'h000, 64'h0, 0, 0, 8'h00, 12'h000, 64'h0);
   endtask

   task automatic push_gnt(input logic p, input logic [7:0] wen,
                           input logic [11:0] a, input logic [63:0] d);
      gnt_t g;
      g.port = p; g.wen = wen; g.a = a; g.d = d;
      exp_gnt.push_back(g);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: samples mid-cycle and pops the scoreboard whenever the DUT presents output.
   always @(negedge CLK) begin
      if (run && !RESET) begin
         gnt_t g;
         check("one_hot_gnt", 64'(GNT0 & GNT1), 64'h0);
         if (GNT0 || GNT1) begin
            if (exp_gnt.size() == 0) begin
               check("unexpected_gnt", 64'(GNT1), 64'h1 ^ 64'(GNT1));
            end else begin
               g = exp_gnt.pop_front();
               $display("grant port %0d A=%h WEn=%h D=%h", GNT1, SRAM_A, SRAM_WEn, SRAM_D);
               check("gnt_port", 64'(GNT1), 64'(g.port));
               check("sram_cen", 64'(SRAM_CEn), 64'h0);
               check("sram_wen", 64'(SRAM_WEn), 64'(g.wen));
               check("sram_a", 64'(SRAM_A), 64'(g.a));
               check("sram_d", SRAM_D, g.d);
            end
         end else begin
            check("idle_cen", 64'(SRAM_CEn), 64'h1);
            check("idle_wen", 64'(SRAM_WEn), 64'hFF);
            check("idle_a", 64'(SRAM_A), 64'h0);
            check("idle_d", SRAM_D, 64'h0);
         end
         if (RVALID0) begin
            if (exp_rd0.size() == 0) check("unexpected_rvalid0", 64'(RVALID0), 64'h0);
            else begin
               $display("read response port 0 data=%h", RDATA0);
               check("rdata0", RDATA0, exp_rd0.pop_front());
            end
         end else check("rdata0_zero", RDATA0, 64'h0);
         if (RVALID1) begin
            if (exp_rd1.size() == 0) check("unexpected_rvalid1", 64'(RVALID1), 64'h0);
            else begin
               $display("read response port 1 data=%h", RDATA1);
               check("rdata1", RDATA1, exp_rd1.pop_front());
            end
         end else check("rdata1_zero", RDATA1, 64'h0);
      end
   end

   localparam logic [63:0] WORD_A = 64'hDEADBEEF_01234567;
   localparam logic [63:0] WORD_B = 64'hFFFFFFFF_00000000;
   int burst_pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   initial begin
      RESET = 1'b1;
      idle();
      repeat (2) @(posedge CLK);
      #1;
      check("rst_gnt0", 64'(GNT0), 64'h0);
      check("rst_gnt1", 64'(GNT1), 64'h0);
      check("rst_rvalid0", 64'(RVALID0), 64'h0);
      check("rst_rvalid1", 64'(RVALID1), 64'h0);
      check("rst_rdata0", RDATA0, 64'h0);
      check("rst_cen", 64'(SRAM_CEn), 64'h1);
      check("rst_wen", 64'(SRAM_WEn), 64'hFF);
      check("rst_a", 64'(SRAM_A), 64'h0);
      check("rst_d", SRAM_D, 64'h0);
      RESET = 1'b0;
      run = 1'b1;

      // Port 0 write then read back
      drive(1, 0, 8'hFF, 12'h801, WORD_A, 0, 0, 8'h00, 12'h000, 64'h0);
      push_gnt(0, 8'h00, 12'h801, WORD_A);
      step();
      drive(1, 0, 8'h00, 12'h801, 64'h0, 0, 0, 8'h00, 12'h000, 64'h0);
      push_gnt(0, 8'hFF, 12'h801, 64'h0);
      exp_rd0.push_back(WORD_A);
      step();
      idle();
      step();

      // Port 1 byte-lane write
      drive(0, 0, 8'h00, 12'h000, 64'h0, 1, 0, 8'hFF, 12'h010, 64'hFFFFFFFF_FFFFFFFF);
      push_gnt(1, 8'h00, 12'h010, 64'hFFFFFFFF_FFFFFFFF);
      step();
      drive(0, 0, 8'h00, 12'h000, 64'h0, 1, 0, 8'h0F, 12'h010, 64'h0);
      push_gnt(1, 8'hF0, 12'h010, 64'h0);
      step();
      drive(0, 0, 8'h00, 12'h000, 64'h0, 1, 0, 8'h00, 12'h010, 64'h0);
      push_gnt(1, 8'hFF, 12'h010, 64'h0);
      exp_rd1.push_back(WORD_B);
      step();
      idle();
      step();

      // Contention without lock: strict alternation starting at port 0
      drive(1, 0, 8'h00, 12'h801, 64'h0, 1, 0, 8'h00, 12'h010, 64'h0);
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            push_gnt(0, 8'hFF, 12'h801, 64'h0);
            exp_rd0.push_back(WORD_A);
         end else begin
            push_gnt(1, 8'hFF, 12'h010, 64'h0);
            exp_rd1.push_back(WORD_B);
         end
         step();
      end
      idle();
      step();

      // Locked burst from port 0 against a steady port 1
      drive(1, 1, 8'h00, 12'h801, 64'h0, 1, 0, 8'h00, 12'h010, 64'h0);
      for (int i = 0; i < 10; i++) begin
         if (burst_pat[i] == 0) begin
            push_gnt(0, 8'hFF, 12'h801, 64'h0);
            exp_rd0.push_back(WORD_A);
         end else begin
            push_gnt(1, 8'hFF, 12'h010, 64'h0);
            exp_rd1.push_back(WORD_B);
         end
         step();
      end
      idle();
      step();

      // Reset lands the cycle after a read grant: the response is dropped
      drive(1, 0, 8'h00, 12'h801, 64'h0, 0, 0, 8'h00, 12'h000, 64'h0);
      push_gnt(0, 8'hFF, 12'h801, 64'h0);
      step();
      idle();
      RESET = 1'b1;
      #1;
      check("rst_drop_rvalid0", 64'(RVALID0), 64'h0);
      check("rst_drop_rdata0", RDATA0, 64'h0);
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      drive(1, 0, 8'h00, 12'h801, 64'h0, 1, 0, 8'h00, 12'h010, 64'h0);
      push_gnt(0, 8'hFF, 12'h801, 64'h0);
      exp_rd0.push_back(WORD_A);
      step();
      idle();
      repeat (2) step();

      check("gnt_queue_empty", 64'(exp_gnt.size()), 64'h0);
      check("rd0_queue_empty", 64'(exp_rd0.size()), 64'h0);
      check("rd1_queue_empty", 64'(exp_rd1.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aha_sram_arbiter.md
# aha_sram_arbiter

Two-requester round-robin arbiter and sequencer for the 32 KB (4K × 64-bit) SoC SRAM macro wrapper. It accepts single-beat read/write requests from two masters, for example the AHB slave bridge on port 0 and the DMA engine on port 1. It drives the wrapper's active-low chip-enable, byte write-enable, address and data pins, and routes the one-cycle-latency read data back to the issuing requester. It sits directly between the bus-side adapters and the SRAM wrapper instance.

## Interface

Parameters:
- `MAX_BURST`, default 4: maximum consecutive grants to one requester holding `LOCKx` while the other requests. Legal range is 1..15.

Ports:
- `CLK`  in  1  — single clock; all state is on its rising edge.
- `RESET`  in  1  — asynchronous, active-high reset.
- `REQ0` / `REQ1`  in  1  — request valid.
- `LOCK0` / `LOCK1`  in  1  — request to keep the grant on the next cycle (burst hint).
- `WE0` / `WE1`  in  8  — active-high byte write enables. All zero means read.
- `ADDR0` / `ADDR1`  in  12  — 64-bit word address.
- `WDATA0` / `WDATA1`  in  64  — write data.
- `GNT0` / `GNT1`  out  1  — request accepted this cycle. Combinational from REQ and arbiter state.
- `RVALID0` / `RVALID1`  out  1  — read data valid, registered.
- `RDATA0` / `RDATA1`  out  64  — read data. Meaningful only while the matching RVALID is high.
- `SRAM_CEn`  out  1  — to wrapper `CEn`, active low.
- `SRAM_WEn`  out  8  — to wrapper `WEn`, active-low per byte.
- `SRAM_A`  out  12  — to wrapper `A`.
- `SRAM_D`  out  64  — to wrapper `D`.
- `SRAM_Q`  in  64  — from wrapper `Q`.

## Operation

- A transfer completes when `REQx && GNTx`. At most one GNT is high per cycle. A requester holds REQ/WE/ADDR/WDATA stable until granted.
- Arbiter state consists of:
  - `last`: the last granted port, reset value 1, so port 0 wins first.
  - `burst_cnt`: 4 bits, reset value 0.
- Grant rules, evaluated in order each cycle:
  1. If only one REQ is high, that port is granted.
  2. If both are high and the port in `last` held LOCK on its previous grant with `burst_cnt < MAX_BURST`, `last` is granted again.
  3. Otherwise, both high grants the port ≠ `last`.
- On any grant:
  - `last` ← the granted port.
  - `burst_cnt` ← `burst_cnt + 1` if the same port was granted in the previous cycle with LOCK high, otherwise 1.
  - `burst_cnt` saturates at 15.
- On a cycle with no grant, `burst_cnt` ← 0 and `last` is unchanged.
- SRAM drive is combinational from the granted port:
  - `SRAM_CEn = ~(GNT0|GNT1)`
  - `SRAM_WEn = ~WEx`
  - `SRAM_A = ADDRx`
  - `SRAM_D = WDATAx`
- When idle, `SRAM_CEn = 1`, `SRAM_WEn = 8'hFF`, `SRAM_A = 0`, and `SRAM_D = 0`.
- Read tracking uses two registered signals:
  - `rd_pend` ← granted && (WE == 0)
  - `rd_port` ← granted port
- RVALID outputs:
  - `RVALID0 = rd_pend && rd_port==0`
  - `RVALID1 = rd_pend && rd_port==1`
- `RDATAx = SRAM_Q` when `RVALIDx` is high, otherwise 0.
- Writes produce no response beyond GNT. Partial byte writes are passed through unchanged.
- Back-to-back accesses from either port are legal every cycle. A read followed by a write to the same address returns the old data.

## Timing

- Reset values:
  - all GNT = 0
  - all RVALID = 0
  - RDATA = 0
  - `SRAM_CEn` = 1, `SRAM_WEn` = 8'hFF, `SRAM_A` = 0, `SRAM_D` = 0
  - `last` = 1, `burst_cnt` = 0, `rd_pend` = 0
- Grant latency is 0 cycles: GNT is high in the same cycle as REQ when the port wins.
- Read latency: a read granted in cycle N gives RVALID in cycle N+1, with RDATA equal to the SRAM word at that address.
- Throughput is one access per cycle aggregate. Under continuous contention without LOCK, the ports alternate 0,1,0,1.
- With LOCK held by the winner under contention, the winner receives exactly `MAX_BURST` consecutive grants, then the other port is granted.
- If RESET asserts in cycle N+1 after a read grant in cycle N, RVALID is forced to 0 immediately (asynchronously) and the response is dropped. The requester must reissue.
- RESET deassertion is synchronized externally. The first grant is possible on the first rising edge after release.

## Test plan

- **Reset and idle:** assert RESET with REQ0=REQ1=0 → all GNT/RVALID 0, `SRAM_CEn`=1, `SRAM_WEn`=8'hFF.
- **Single write then read, port 0:**
  - Cycle 1: REQ0, WE0=8'hFF, ADDR0=12'h801, WDATA0=64'hDEADBEEF_01234567 → GNT0=1, `SRAM_CEn`=0, `SRAM_WEn`=8'h00.
  - Cycle 2: read of 12'h801 → GNT0=1.
  - Cycle 3: RVALID0=1, RDATA0=64'hDEADBEEF_01234567, RVALID1=0.
- **Byte-lane write:** write all-ones to 12'h010, then write 64'h0 with WE1=8'h0F from port 1, then read → 64'hFFFFFFFF_00000000.
- **Contention, no LOCK:** REQ0=REQ1=1 for 6 cycles, both reading distinct addresses → grants 0,1,0,1,0,1, and each RVALID matches its port one cycle later.
- **Burst lock, MAX_BURST=4:** REQ0+LOCK0 and REQ1 held for 10 cycles → grants 0,0,0,0,1,0,0,0,0,1.
- **Reset mid-read:** grant a read, then assert RESET in the next cycle → RVALID stays 0, and after release the first contended grant goes to port 0.
